// File: rtl/uart_rx_deserializer_pkg.sv
// rtl/uart_rx_deserializer_pkg.sv - shared UART receiver types and defaults
package uart_rx_deserializer_pkg;

  // 50 MHz system clock at 57600 baud; the transmitter uses the same default
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_deserializer_sync_2ff.sv
// rtl/uart_rx_deserializer_sync_2ff.sv - two-flop synchronizer, resets to line idle (1)
module uart_rx_deserializer_sync_2ff (
  input  logic clock,
  input  logic resetN,
  input  logic d,
  output logic q
);

  logic meta;

  // Two register stages; both preset high so a reset never looks like a start bit
  always_ff @(posedge clock) begin
    if (!resetN) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_deserializer.sv
// rtl/uart_rx_deserializer.sv - 8N1 UART receiver with single-entry holding register
module uart_rx_deserializer
  import uart_rx_deserializer_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clock,
  input  logic                 resetN,
  input  logic                 rx,
  input  logic                 rxRead,
  output logic [DATA_BITS-1:0] rxData,
  output logic                 rxValid,
  output logic                 overrun,
  output logic                 framingError
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  logic                 rxS;
  rx_state_t            state;
  rx_state_t            state_next;
  logic [CW-1:0]        baud_cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 cnt_clear;
  logic                 bit_strobe;
  logic                 stop_good;
  logic                 stop_bad;

  uart_rx_deserializer_sync_2ff u_sync (
    .clock  (clock),
    .resetN (resetN),
    .d      (rx),
    .q      (rxS)
  );

  // Next-state and per-cycle strobes; the baud counter restarts on every state change
  always_comb begin
    state_next = state;
    bit_strobe = 1'b0;
    stop_good  = 1'b0;
    stop_bad   = 1'b0;
    cnt_clear  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rxS) state_next = ST_START;
      end
      ST_START: begin
        // Re-check the line half a bit in; a short low pulse is treated as noise
        if (baud_cnt == HALF_LAST) state_next = rxS ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (baud_cnt == BIT_LAST) begin
          bit_strobe = 1'b1;
          if (bit_idx == IDX_LAST) state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (baud_cnt == BIT_LAST) begin
          if (rxS) begin
            stop_good  = 1'b1;
            state_next = ST_IDLE;
          end else begin
            stop_bad   = 1'b1;
            state_next = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        // Hold here through a break so a long low line cannot start a new frame
        if (rxS) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    cnt_clear = (state_next != state) || bit_strobe;
  end

  // State register, baud counter and data bit index
  always_ff @(posedge clock) begin
    if (!resetN) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      state    <= state_next;
      baud_cnt <= cnt_clear ? '0 : baud_cnt + CW'(1);
      if (state != ST_DATA) bit_idx <= '0;
      else if (bit_strobe)  bit_idx <= bit_idx + IW'(1);
    end
  end

  // Assemble the frame LSB first, one bit per mid-bit sample
  always_ff @(posedge clock) begin
    if (!resetN) begin
      shift_reg <= '0;
    end else if (bit_strobe) begin
      shift_reg[bit_idx] <= rxS;
    end
  end

  // Holding register, read handshake, sticky overrun and framing pulse
  always_ff @(posedge clock) begin
    if (!resetN) begin
      rxData       <= '0;
      rxValid      <= 1'b0;
      overrun      <= 1'b0;
      framingError <= 1'b0;
    end else begin
      framingError <= stop_bad;
      if (stop_good) begin
        rxData  <= shift_reg;
        rxValid <= 1'b1;
        // A pop in the same cycle frees the slot, so only an unread byte is lost
        if (rxValid && !rxRead) overrun <= 1'b1;
      end else if (rxRead) begin
        rxValid <= 1'b0;
      end
    end
  end

endmodule
